// File: rtl/key_edge_pio.sv
// key_edge_pio
// Avalon-MM pushbutton PIO with a debounced input per key and a
// falling-edge capture register that can raise a level interrupt.
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   reset_n     asynchronous active-low reset
//   address     register select (0 data, 1 reserved, 2 irq mask, 3 edge capture)
//   chipselect  slave select, qualifies writes
//   write_n     active-low write strobe
//   writedata   write data, bits above WIDTH ignored
//   readdata    combinational read data, zero-extended to 32 bits
//   in_port     asynchronous active-low keys (1 = released)
//   irq         registered interrupt, |(edge_capture & irq_mask) of the previous cycle
module key_edge_pio #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] debounced_prev;
    logic [15:0]      db_count [WIDTH];
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] falls;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;
    logic [31:0]      read_mux;
    logic             unused_wdata;

    // Writedata bits above WIDTH carry no meaning; fold them into one
    // deliberately unused net so the full bus is still consumed.
    assign unused_wdata = &{1'b0, writedata};

    assign wr_en = chipselect && !write_n;

    // Reset to all ones so keys read as released until proven otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta <= '1;
            sync_out  <= '1;
        end else begin
            sync_meta <= in_port;
            sync_out  <= sync_meta;
        end
    end

    // The counter only runs while the synchronized key disagrees with the
    // debounced value; any return to agreement throws the count away, so
    // only a disagreement lasting DB_CYCLES cycles gets through.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debounced <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                db_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_out[i] == debounced[i]) begin
                    db_count[i] <= '0;
                end else if (db_count[i] == DB_LAST) begin
                    debounced[i] <= sync_out[i];
                    db_count[i]  <= '0;
                end else begin
                    db_count[i] <= db_count[i] + 16'd1;
                end
            end
        end
    end

    // A press is a 1->0 transition of the debounced key.
    assign falls = debounced_prev & ~debounced;

    assign clear_bits = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Set takes priority over write-1-to-clear so a press landing in the
    // same cycle as a clear is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debounced_prev <= '1;
            edge_capture   <= '0;
            irq_mask       <= '0;
            irq            <= 1'b0;
        end else begin
            debounced_prev <= debounced;
            edge_capture   <= (edge_capture & ~clear_bits) | falls;
            if (wr_en && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            irq <= |(edge_capture & irq_mask);
        end
    end

    // Reads are not gated by chipselect; unused upper bits stay zero.
    always_comb begin
        read_mux = '0;
        case (address)
            2'd0:    read_mux[WIDTH-1:0] = debounced;
            2'd2:    read_mux[WIDTH-1:0] = irq_mask;
            2'd3:    read_mux[WIDTH-1:0] = edge_capture;
            default: read_mux = '0;
        endcase
    end

    assign readdata = read_mux;

endmodule

// File: tb/tb_key_edge_pio.sv
// tb_key_edge_pio
// Directed bench for key_edge_pio with WIDTH=4, DB_CYCLES=8. Inputs are
// driven 1 ns after a rising edge so each change is seen by the next edge;
// edge numbering below counts rising edges after the input change.
module tb_key_edge_pio;

    localparam int WIDTH     = 4;
    localparam int DB_CYCLES = 8;

    logic             clk;
    logic             reset_n;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int tests_run;
    int tests_failed;
    logic [31:0] rd;

    key_edge_pio #(
        .WIDTH     (WIDTH),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and park 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the keys, then let the given number of edges pass.
    task automatic applyStimulus(input logic [WIDTH-1:0] keys, input int cycles);
        in_port = keys;
        step(cycles);
    endtask

    // Single write cycle; the register updates on the edge inside this task.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        address      = 2'd0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        writedata    = '0;
        in_port      = 4'hF;

        // Reset state
        step(3);
        read_reg(2'd0, rd); checkOutput("reset_data", rd, 32'h0000000F);
        read_reg(2'd2, rd); checkOutput("reset_mask", rd, 32'h0);
        read_reg(2'd3, rd); checkOutput("reset_edge", rd, 32'h0);
        checkOutput("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        step(2);

        // Press bit0: debounced at edge 10, captured at edge 11
        applyStimulus(4'hE, 9);
        read_reg(2'd0, rd); checkOutput("press0_data_e9", rd, 32'h0000000F);
        step(1);
        read_reg(2'd0, rd); checkOutput("press0_data_e10", rd, 32'h0000000E);
        read_reg(2'd3, rd); checkOutput("press0_edge_e10", rd, 32'h0);
        step(1);
        read_reg(2'd3, rd); checkOutput("press0_edge_e11", rd, 32'h1);
        checkOutput("press0_irq_unmasked", {31'b0, irq}, 32'h0);

        // Release: rising edge must not touch the capture register
        applyStimulus(4'hF, 12);
        read_reg(2'd0, rd); checkOutput("release0_data", rd, 32'h0000000F);
        read_reg(2'd3, rd); checkOutput("release0_edge", rd, 32'h1);
        bus_write(2'd3, 32'h1);
        read_reg(2'd3, rd); checkOutput("clear0_edge", rd, 32'h0);

        // Short glitch on bit1 is filtered
        applyStimulus(4'hD, 5);
        applyStimulus(4'hF, 12);
        read_reg(2'd0, rd); checkOutput("glitch5_data", rd, 32'h0000000F);
        read_reg(2'd3, rd); checkOutput("glitch5_edge", rd, 32'h0);
        checkOutput("glitch5_irq", {31'b0, irq}, 32'h0);

        // Longest glitch that is still rejected: DB_CYCLES-1 cycles
        applyStimulus(4'hD, DB_CYCLES - 1);
        applyStimulus(4'hF, 12);
        read_reg(2'd0, rd); checkOutput("glitch7_data", rd, 32'h0000000F);
        read_reg(2'd3, rd); checkOutput("glitch7_edge", rd, 32'h0);

        // Mask register width and reserved address
        bus_write(2'd2, 32'hFFFFFFFF);
        read_reg(2'd2, rd); checkOutput("mask_all", rd, 32'h0000000F);
        bus_write(2'd1, 32'hFFFFFFFF);
        read_reg(2'd1, rd); checkOutput("addr1_zero", rd, 32'h0);
        bus_write(2'd2, 32'h4);
        read_reg(2'd2, rd); checkOutput("mask_4", rd, 32'h4);
        // Write without chipselect is ignored
        address    = 2'd2;
        writedata  = 32'hF;
        write_n    = 1'b0;
        chipselect = 1'b0;
        step(1);
        write_n    = 1'b1;
        read_reg(2'd2, rd); checkOutput("mask_no_cs", rd, 32'h4);

        // Masked press on bit2 raises irq one cycle after capture
        applyStimulus(4'hB, 11);
        read_reg(2'd3, rd); checkOutput("press2_edge", rd, 32'h4);
        checkOutput("press2_irq_e11", {31'b0, irq}, 32'h0);
        step(1);
        checkOutput("press2_irq_e12", {31'b0, irq}, 32'h1);
        bus_write(2'd3, 32'h4);
        read_reg(2'd3, rd); checkOutput("clear2_edge", rd, 32'h0);
        checkOutput("clear2_irq_same", {31'b0, irq}, 32'h1);
        step(1);
        checkOutput("clear2_irq_next", {31'b0, irq}, 32'h0);
        applyStimulus(4'hF, 12);

        // Clear lands on the same edge the bit0 press is captured
        applyStimulus(4'hE, 10);
        bus_write(2'd3, 32'h1);
        read_reg(2'd3, rd); checkOutput("set_wins_edge", rd, 32'h1);
        step(1);
        checkOutput("set_wins_irq", {31'b0, irq}, 32'h0);
        bus_write(2'd3, 32'h1);
        read_reg(2'd3, rd); checkOutput("set_wins_clear", rd, 32'h0);
        applyStimulus(4'hF, 12);

        // Async reset mid-debounce while irq is high
        applyStimulus(4'hB, 12);
        checkOutput("pre_reset_irq", {31'b0, irq}, 32'h1);
        applyStimulus(4'hF, 4);
        reset_n = 1'b0;
        #1;
        checkOutput("async_irq", {31'b0, irq}, 32'h0);
        read_reg(2'd2, rd); checkOutput("async_mask", rd, 32'h0);
        read_reg(2'd3, rd); checkOutput("async_edge", rd, 32'h0);
        read_reg(2'd0, rd); checkOutput("async_data", rd, 32'h0000000F);

        // Key held low through reset is seen as a fresh press afterwards
        applyStimulus(4'hE, 3);
        read_reg(2'd0, rd); checkOutput("held_in_reset", rd, 32'h0000000F);
        reset_n = 1'b1;
        step(9);
        read_reg(2'd0, rd); checkOutput("held_data_e9", rd, 32'h0000000F);
        step(1);
        read_reg(2'd0, rd); checkOutput("held_data_e10", rd, 32'h0000000E);
        step(1);
        read_reg(2'd3, rd); checkOutput("held_edge_e11", rd, 32'h1);
        checkOutput("held_irq_masked_off", {31'b0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
